// File: rtl/prng_word_sched.sv
// ============================================================================
// prng_word_sched : shares one 4-bit serial PRNG among NREQ requesters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prng_word_sched #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]  req_i,
    input  logic [3:0]       seed_in_i,
    input  logic             seed_vld_i,
    output logic             seed_ack_o,
    output logic [NREQ-1:0]  gnt_o,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             busy_o,
    output logic [1:0]       mode_o,
    output logic [3:0]       seed_o,
    input  logic             sout_i
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [OW:0]   NREQ_W   = (OW+1)'(NREQ);
    localparam logic [OW-1:0] LAST_REQ = OW'(NREQ - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_STEP = 2'b11;

    logic [2:0]       state_q,    state_d;
    logic [1:0]       mode_q,     mode_d;
    logic [3:0]       seed_q,     seed_d;
    logic             seed_ack_q, seed_ack_d;
    logic [NREQ-1:0]  gnt_q,      gnt_d;
    logic             rvalid_q,   rvalid_d;
    logic [WIDTH-1:0] rdata_q,    rdata_d;
    logic [OW-1:0]    owner_q,    owner_d;
    logic [OW-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             step_q,     step_d;

    // Rotate requests so bit 0 is the rr_ptr requester; lowest set bit wins.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              arb_found;
    logic [OW:0]       arb_off;
    logic [OW:0]       arb_sum;
    logic [OW-1:0]     arb_owner;

    assign req_dbl = {req_i, req_i} >> rr_ptr_q;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        arb_found = 1'b0;
        arb_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_found = 1'b1;
                arb_off   = (OW+1)'(i);
            end
        end
        arb_sum   = {1'b0, rr_ptr_q} + arb_off;
        arb_owner = (arb_sum >= NREQ_W) ? OW'(arb_sum - NREQ_W) : arb_sum[OW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = M_HOLD;
        seed_d     = seed_q;
        seed_ack_d = 1'b0;
        gnt_d      = '0;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        step_d     = (mode_q == M_STEP);

        // SOUT shows the result of the previous step cycle.
        if (step_q) begin
            rdata_d = {rdata_q[WIDTH-2:0], sout_i};
        end

        case (state_q)
            S_IDLE: begin
                if (seed_vld_i) begin
                    state_d    = S_LOAD;
                    mode_d     = M_LOAD;
                    seed_d     = seed_in_i;
                    seed_ack_d = 1'b1;
                end else if (arb_found) begin
                    state_d = S_SHIFT;
                    mode_d  = M_STEP;
                    owner_d = arb_owner;
                    rdata_d = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DRAIN;
                end else begin
                    mode_d = M_STEP;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d  = S_DONE;
                rvalid_d = 1'b1;
                gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= M_HOLD;
            seed_q     <= '0;
            seed_ack_q <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            seed_ack_q <= seed_ack_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
        end
    end

    assign seed_ack_o = seed_ack_q;
    assign gnt_o      = gnt_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q != S_IDLE);
    assign mode_o     = mode_q;
    assign seed_o     = seed_q;

endmodule

`default_nettype wire

// File: tb/tb_prng_word_sched.sv
// ============================================================================
// tb_prng_word_sched : directed + randomized bench with a serial PRNG stand-in
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_prng_word_sched;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;

    logic             clk        = 1'b0;
    logic             rst_ni     = 1'b0;
    logic [NREQ-1:0]  req_i      = '0;
    logic [3:0]       seed_in_i  = '0;
    logic             seed_vld_i = 1'b0;
    logic             sout_i     = 1'b0;
    logic             seed_ack_o;
    logic [NREQ-1:0]  gnt_o;
    logic             rvalid_o;
    logic [WIDTH-1:0] rdata_o;
    logic             busy_o;
    logic [1:0]       mode_o;
    logic [3:0]       seed_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int steps    = 0;
    int exp_ptr  = 0;
    bit step_seen = 1'b0;
    bit               sq[$];
    logic [WIDTH-1:0] exp_q[$];

    prng_word_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .seed_in_i  (seed_in_i),
        .seed_vld_i (seed_vld_i),
        .seed_ack_o (seed_ack_o),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .mode_o     (mode_o),
        .seed_o     (seed_o),
        .sout_i     (sout_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // PRNG stand-in: every step cycle presents the next queued bit on SOUT.
    always @(negedge clk) begin
        step_seen = (mode_o == 2'b11);
        if (step_seen) steps++;
    end

    always @(posedge clk) begin
        if (step_seen) begin
            #1;
            if (sq.size() > 0) sout_i = sq.pop_front();
            else               sout_i = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int k = WIDTH - 1; k >= 0; k--) sq.push_back(w[k]);
        exp_q.push_back(w);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr + i) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic wait_word(input string tag, input int owner, output int at);
        int n;
        logic [WIDTH-1:0] ew;
        n = 0;
        while (rvalid_o !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        at = cyc;
        if (rvalid_o !== 1'b1) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            ew = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            chk({tag, "_gnt"}, 32'(gnt_o), 32'(1 << owner));
            chk({tag, "_rdata"}, 32'(rdata_o), 32'(ew));
            chk({tag, "_steps"}, 32'(steps), 32'(WIDTH));
            chk({tag, "_noack"}, 32'(seed_ack_o), 32'd0);
            steps   = 0;
            exp_ptr = (owner + 1) % NREQ;
        end
    endtask

    initial begin
        int e, at, prev, owner, seen;
        logic [NREQ-1:0] r;
        logic [3:0] s;
        bit drop;

        // Reset held with requests pending
        req_i = '1;
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("rst_mode", 32'(mode_o), 32'd0);
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_rvalid", 32'(rvalid_o), 32'd0);
            chk("rst_rdata", 32'(rdata_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
        end
        rst_ni = 1'b1;
        req_i  = '0;
        tick;
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Seed load from IDLE
        seed_in_i  = 4'h1;
        seed_vld_i = 1'b1;
        tick;
        chk("seed_mode", 32'(mode_o), 32'd1);
        chk("seed_val", 32'(seed_o), 32'h1);
        chk("seed_ack", 32'(seed_ack_o), 32'd1);
        seed_vld_i = 1'b0;
        tick;
        chk("seed_mode_after", 32'(mode_o), 32'd0);
        chk("seed_ack_after", 32'(seed_ack_o), 32'd0);

        // Fixed word: SOUT 1,0,1,1,0,0,1,0 packs to B2
        push_word(8'hB2);
        steps = 0;
        req_i = 2'b01;
        tick;
        e = cyc;
        owner = pick(2'b01, exp_ptr);
        wait_word("word", owner, at);
        // GNT/RVALID occupy the cycle begun by the (WIDTH+1)th edge after sampling
        chk("word_latency", 32'(at - e), 32'(WIDTH + 1));
        req_i = '0;
        tick;
        tick;
        chk("rdata_hold", 32'(rdata_o), 32'hB2);

        // Seed and request on the same IDLE edge: seed goes first
        s = 4'($urandom);
        push_word(WIDTH'($urandom));
        steps      = 0;
        seed_in_i  = s;
        seed_vld_i = 1'b1;
        req_i      = 2'b10;
        tick;
        e = cyc;
        chk("coll_ack", 32'(seed_ack_o), 32'd1);
        chk("coll_seed", 32'(seed_o), 32'(s));
        chk("coll_gnt0", 32'(gnt_o), 32'd0);
        seed_vld_i = 1'b0;
        owner = pick(2'b10, exp_ptr);
        wait_word("coll", owner, at);
        // LOAD cycle, then the request is sampled at the end of the next IDLE cycle
        chk("coll_latency", 32'(at - e), 32'(WIDTH + 3));
        req_i = '0;
        tick;

        // Fairness with both requesters held
        for (int k = 0; k < 4; k++) push_word(WIDTH'($urandom));
        steps = 0;
        req_i = 2'b11;
        prev  = 0;
        for (int k = 0; k < 4; k++) begin
            owner = pick(2'b11, exp_ptr);
            chk("fair_owner", 32'(owner), 32'(k % 2));
            wait_word("fair", owner, at);
            if (k > 0) chk("fair_spacing", 32'(at - prev), 32'(WIDTH + 3));
            prev = at;
            if (k == 3) req_i = '0;
            tick;
        end

        // Reset in the middle of SHIFT (cnt=3)
        push_word(WIDTH'($urandom));
        steps = 0;
        req_i = 2'b01;
        tick;
        for (int k = 0; k < 3; k++) tick;
        chk("abort_in_shift", 32'(mode_o), 32'd3);
        rst_ni = 1'b0;
        tick;
        chk("abort_mode", 32'(mode_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_gnt", 32'(gnt_o), 32'd0);
        rst_ni = 1'b1;
        req_i  = '0;
        seen   = 0;
        for (int k = 0; k < 14; k++) begin
            tick;
            if (rvalid_o !== 1'b0 || gnt_o !== '0) seen++;
        end
        chk("abort_no_word", 32'(seen), 32'd0);
        sq.delete();
        exp_q.delete();
        exp_ptr = 0;
        steps   = 0;

        push_word(WIDTH'($urandom));
        req_i = 2'b11;
        tick;
        e = cyc;
        owner = pick(2'b11, exp_ptr);
        wait_word("post_abort", owner, at);
        chk("post_abort_latency", 32'(at - e), 32'(WIDTH + 1));
        req_i = '0;
        tick;

        // Randomized requests, optional seed loads and early REQ drops
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = 4'($urandom);
                seed_in_i  = s;
                seed_vld_i = 1'b1;
                tick;
                chk("rnd_seed_ack", 32'(seed_ack_o), 32'd1);
                chk("rnd_seed_val", 32'(seed_o), 32'(s));
                seed_vld_i = 1'b0;
                tick;
            end
            r    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drop = 1'($urandom_range(0, 1));
            push_word(WIDTH'($urandom));
            steps = 0;
            owner = pick(r, exp_ptr);
            req_i = r;
            tick;
            e = cyc;
            if (drop) req_i = '0;
            wait_word("rnd", owner, at);
            chk("rnd_latency", 32'(at - e), 32'(WIDTH + 1));
            req_i = '0;
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
